pulse_stretcher: RTL

- Inverse of the edge-to-pulse conditioning in io_circuits: converts single-cycle pulses into fixed-width, human- or peripheral-visible level pulses.
- Vector of independent channels.
- Typical use: drive LEDs from one-cycle CPU/UART events, or hold strobes long enough for slow external logic.
- Sits between core-side event pulses and board-level outputs.

---
 rtl/pulse_stretcher_pkg.sv | 26 ++
 rtl/pulse_stretcher_channel.sv | 71 +++++++
 rtl/pulse_stretcher.sv | 43 ++++
 3 files changed

// File: rtl/pulse_stretcher_pkg.sv
// Shared constants for the pulse stretcher: counter sizing helper and the
// per-channel one-shot state encodings.
package pulse_stretcher_pkg;

  // One-shot channel states, kept as plain constants for legacy tools
  localparam logic [0:0] STATE_IDLE   = 1'b0;
  localparam logic [0:0] STATE_ACTIVE = 1'b1;

  // Ceiling log2, shared with the debouncer and counter blocks
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Counter width for a given stretch length; never narrower than one bit
  function automatic int cnt_width(input int stretch_cycles);
    int w;
    w = clog2(stretch_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pulse_stretcher_channel.sv
// Single-bit one-shot: a one-cycle trigger yields an output level that is
// high for exactly stretch_cycles clocks.
// Build option: define PULSE_STRETCHER_RETRIGGER_EN to make a trigger seen
// while active reload the counter (retriggerable); otherwise triggers during
// the active window are ignored.
module pulse_stretcher_channel
  import pulse_stretcher_pkg::*;
#(
  parameter int stretch_cycles = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic out,
  output logic next_out
);

  localparam int cnt_w = cnt_width(stretch_cycles);
  localparam logic [cnt_w-1:0] RELOAD = cnt_w'(stretch_cycles - 1);

  logic [0:0]       r_state;
  logic [cnt_w-1:0] r_cnt;
  logic [0:0]       w_stateNext;
  logic [cnt_w-1:0] w_cntNext;

  // Next-state: load on trigger, count down while active, drop after cnt hits 0
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    case (r_state)
      STATE_IDLE: begin
        if (trig) begin
          w_stateNext = STATE_ACTIVE;
          w_cntNext   = RELOAD;
        end
      end
      default: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        if (trig) begin
          w_cntNext = RELOAD;
        end else if (r_cnt != '0) begin
          w_cntNext = r_cnt - cnt_w'(1);
        end else begin
          w_stateNext = STATE_IDLE;
        end
`else
        if (r_cnt != '0) begin
          w_cntNext = r_cnt - cnt_w'(1);
        end else begin
          w_stateNext = STATE_IDLE;
        end
`endif
      end
    endcase
  end

  // State and counter registers; reset discards any pending count and trigger
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= STATE_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  assign out      = (r_state == STATE_ACTIVE);
  assign next_out = ~rst & (w_stateNext == STATE_ACTIVE);

endmodule

// File: rtl/pulse_stretcher.sv
// Vector of independent pulse stretchers plus a registered "any channel
// active" flag.
// Build option: PULSE_STRETCHER_RETRIGGER_EN selects retriggerable channels.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int width          = 1,
  parameter int stretch_cycles = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] pulse_in,
  output logic [width-1:0] stretched_out,
  output logic             any_active
);

  logic [width-1:0] w_nextActive;
  logic             r_anyActive;

  for (genvar i = 0; i < width; i++) begin : g_channel
    pulse_stretcher_channel #(
      .stretch_cycles(stretch_cycles)
    ) u_channel (
      .clk     (clk),
      .rst     (rst),
      .trig    (pulse_in[i]),
      .out     (stretched_out[i]),
      .next_out(w_nextActive[i])
    );
  end

  // Register the OR of next-state flags so it lines up with stretched_out
  always_ff @(posedge clk) begin
    if (rst) begin
      r_anyActive <= 1'b0;
    end else begin
      r_anyActive <= |w_nextActive;
    end
  end

  assign any_active = r_anyActive;

endmodule
